// File: rtl/sr_load_sequencer.sv
// sr_load_sequencer
//   Serialises a static (SIZESRSTAT-bit) or dynamic (SIZESRDYN-bit) word into
//   an external shift-register chain, MSB first, then strobes LATCH. The old
//   chain contents coming back on SER_IN are captured into RDBK_DATA.
//   Concurrent requests are served round-robin, with DYN first after reset.
//
// Ports
//   CLK, RST             clock (rising edge), synchronous active-high reset
//   STAT_REQ/STAT_DATA   static load request (level) and word
//   DYN_REQ/DYN_DATA     dynamic load request (level) and word
//   SER_IN               serial return from the chain
//   STAT_ACK/DYN_ACK     one-cycle grant; data is sampled in this cycle
//   SELSTAT/SELDYN       chain select, high only while shifting
//   SER_OUT              serial data to the chain
//   LATCH/LATCH_DYN      one-cycle latch strobe and its chain type
//   BUSY                 high whenever the sequencer is not idle
//   RDBK_DATA            previous chain contents
module sr_load_sequencer #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  STAT_REQ,
    input  logic [SIZESRSTAT-1:0] STAT_DATA,
    input  logic                  DYN_REQ,
    input  logic [SIZESRDYN-1:0]  DYN_DATA,
    input  logic                  SER_IN,
    output logic                  STAT_ACK,
    output logic                  DYN_ACK,
    output logic                  SELSTAT,
    output logic                  SELDYN,
    output logic                  SER_OUT,
    output logic                  LATCH,
    output logic                  LATCH_DYN,
    output logic                  BUSY,
    output logic [SIZESRSTAT-1:0] RDBK_DATA
);

    localparam int CW = $clog2(SIZESRSTAT + 1);
    localparam logic [CW-1:0] NSTAT = CW'(SIZESRSTAT);
    localparam logic [CW-1:0] NDYN  = CW'(SIZESRDYN);
    localparam logic [SIZESRSTAT-1:0] DYN_MASK = SIZESRSTAT'({SIZESRDYN{1'b1}});

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CW-1:0]           r_cnt;
    logic [SIZESRSTAT-1:0]   r_sbuf;
    logic [SIZESRSTAT-1:0]   r_rdbk;
    logic                    r_is_dyn;
    logic                    r_last_dyn;
    logic                    w_grant_dyn;
    logic                    w_grant_stat;
    logic [SIZESRSTAT-1:0]   w_dyn_aligned;

    // Dynamic word is MSB-aligned in the shared buffer so both types shift
    // out of the same top bit.
    assign w_dyn_aligned = SIZESRSTAT'(DYN_DATA) << (SIZESRSTAT - SIZESRDYN);

    // DYN wins unless STAT also requests and DYN was served last.
    assign w_grant_dyn  = DYN_REQ && (!STAT_REQ || !r_last_dyn);
    assign w_grant_stat = STAT_REQ && !w_grant_dyn;

    assign RDBK_DATA = r_rdbk;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        STAT_ACK    = 1'b0;
        DYN_ACK     = 1'b0;
        SELSTAT     = 1'b0;
        SELDYN      = 1'b0;
        SER_OUT     = 1'b0;
        LATCH       = 1'b0;
        LATCH_DYN   = 1'b0;
        BUSY        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Grant is suppressed while reset is held so all outputs stay 0.
                if (!RST) begin
                    if (w_grant_dyn) begin
                        DYN_ACK     = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end else if (w_grant_stat) begin
                        STAT_ACK    = 1'b1;
                        w_state_nxt = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                BUSY    = 1'b1;
                SELDYN  = r_is_dyn;
                SELSTAT = !r_is_dyn;
                SER_OUT = r_sbuf[SIZESRSTAT-1];
                if (r_cnt == CW'(1)) w_state_nxt = ST_LATCH;
            end
            ST_LATCH: begin
                BUSY        = 1'b1;
                LATCH       = 1'b1;
                LATCH_DYN   = r_is_dyn;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt      <= '0;
            r_sbuf     <= '0;
            r_rdbk     <= '0;
            r_is_dyn   <= 1'b0;
            r_last_dyn <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (DYN_ACK) begin
                        r_sbuf     <= w_dyn_aligned;
                        r_cnt      <= NDYN;
                        r_is_dyn   <= 1'b1;
                        r_last_dyn <= 1'b1;
                        r_rdbk     <= r_rdbk & DYN_MASK;
                    end else if (STAT_ACK) begin
                        r_sbuf     <= STAT_DATA;
                        r_cnt      <= NSTAT;
                        r_is_dyn   <= 1'b0;
                        r_last_dyn <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    r_sbuf <= r_sbuf << 1;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_is_dyn)
                        r_rdbk[SIZESRDYN-1:0] <= {r_rdbk[SIZESRDYN-2:0], SER_IN};
                    else
                        r_rdbk <= {r_rdbk[SIZESRSTAT-2:0], SER_IN};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/sr_load_sequencer.md
SR_LOAD_SEQUENCER -- requirements
Module: sr_load_sequencer

Interface
REQ-001 SHALL have parameter SIZESRSTAT, default 88, meaning static shift-register length in bits.
REQ-002 SHALL have parameter SIZESRDYN, default 16, meaning dynamic shift-register length in bits.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port STAT_REQ  input  1  static load request, level, held until STAT_ACK.
REQ-006 SHALL have port STAT_DATA  input  SIZESRSTAT  static word, sampled on the STAT_ACK cycle.
REQ-007 SHALL have port DYN_REQ  input  1  dynamic load request, level, held until DYN_ACK.
REQ-008 SHALL have port DYN_DATA  input  SIZESRDYN  dynamic word, sampled on the DYN_ACK cycle.
REQ-009 SHALL have port SER_IN  input  1  serial return from chain (generator signal_out).
REQ-010 SHALL have port STAT_ACK / DYN_ACK  output  1 each  one-cycle grant pulse.
REQ-011 SHALL have port SELSTAT / SELDYN  output  1 each  chain select to generator.
REQ-012 SHALL have port SER_OUT  output  1  serial data to chain (generator signal_in).
REQ-013 SHALL have port LATCH  output  1  one-cycle latch strobe after final shift.
REQ-014 SHALL have port LATCH_DYN  output  1  qualifies LATCH: 1 = dynamic, 0 = static.
REQ-015 SHALL have port BUSY  output  1  high in every non-IDLE state.
REQ-016 SHALL have port RDBK_DATA  output  SIZESRSTAT  previous chain contents captured from SER_IN.

Function
REQ-017 SHALL implement FSM states IDLE, SHIFT, LATCH; no other reachable states.
REQ-018 IDLE with at least one REQ: grant one requester (ACK pulse same cycle), capture its data into a shift buffer, load counter with N (N = SIZESRSTAT or SIZESRDYN), go to SHIFT.
REQ-019 Both REQ high in IDLE: round-robin -- grant the type not granted last; after reset, DYN wins first.
REQ-020 SHIFT: exactly N cycles; selected SELx = 1, other SELx = 0; SER_OUT = data MSB first (bit N-1 in first SHIFT cycle, bit 0 in last).
REQ-021 SHIFT: each cycle shift SER_IN into RDBK_DATA LSB; for dynamic loads only RDBK_DATA[SIZESRDYN-1:0] updated, upper bits cleared on grant.
REQ-022 After the Nth SHIFT cycle go to LATCH: SELSTAT = SELDYN = 0, LATCH = 1 one cycle, LATCH_DYN = type served; then IDLE.
REQ-023 Timing: ACK in cycle T, SHIFT T+1..T+N, LATCH T+N+1, IDLE T+N+2 (earliest next ACK).
REQ-024 SELSTAT and SELDYN SHALL never be high simultaneously; SER_OUT = 0 outside SHIFT.
REQ-025 REQ changes during SHIFT/LATCH ignored; data inputs not resampled after grant.
REQ-026 REQ deasserted before grant: no transfer, no ACK.
REQ-027 RDBK_DATA SHALL hold its value outside SHIFT.

Reset
REQ-028 RST high at a rising edge: state IDLE, counter 0, buffers 0, RDBK_DATA 0, round-robin pointer to DYN-first, all outputs 0.
REQ-029 RST during SHIFT or LATCH SHALL abort the transfer with no LATCH pulse; next cycle after RST low is IDLE.

Verification
REQ-030 DYN_REQ=1, DYN_DATA=16'h8001 -> DYN_ACK one cycle, SELDYN high 16 cycles, SER_OUT 1,0x14,1, then LATCH=1 with LATCH_DYN=1, BUSY low after 18 cycles.
REQ-031 STAT_REQ=1, STAT_DATA=88'hA1B2C3D4E5F67890ABCDE1 with SER_IN looped from SER_OUT through an 88-bit model shift register preloaded 0 -> SELSTAT 88 cycles, LATCH_DYN=0; second identical load -> RDBK_DATA = 88'hA1B2C3D4E5F67890ABCDE1.
REQ-032 STAT_REQ and DYN_REQ both held high from reset -> grants alternate DYN, STAT, DYN, STAT; ACK spacing N+2 cycles.
REQ-033 RST pulsed at 5th SHIFT cycle of a static load -> all outputs 0 next cycle, no LATCH, next held request granted fresh.
REQ-034 STAT_DATA changed during SHIFT -> SER_OUT stream unchanged; REQ pulse dropped before IDLE -> no ACK, BUSY stays 0.
